// File: rtl/seq_packetizer.sv
// Transmit-side packet builder: turns one message per handshake into a
// two-word header plus zero-padded payload words, with per-stream sequencing.
module seq_packetizer (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [0:295] msgIn,
  input  logic [5:0]   msgIn_len,
  input  logic [15:0]  msgIn_stream,
  input  logic         msgIn_val,
  output logic         msgIn_ready,
  output logic [31:0]  dataOut,
  output logic         dataOut_val,
  input  logic         dataOut_ready,
  output logic         dataOut_last,
  output logic         lenErr
);

  localparam int unsigned NUM_STREAMS       = 32;
  localparam int unsigned MAX_PAYLOAD_BYTES = 37;
  localparam int unsigned PAYLOAD_W         = MAX_PAYLOAD_BYTES * 8;
  localparam int unsigned PAD_W             = 320;

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} stateT;

  stateT             state, stateNext;
  logic [0:PAYLOAD_W-1] payloadReg;
  logic [0:PAD_W-1]  padded;
  logic [5:0]        lenReg;
  logic [15:0]       streamReg;
  logic [31:0]       seqReg;
  logic [3:0]        wordIdx, wordIdxNext;
  logic [3:0]        lastIdx;
  logic [31:0]       seqTable [NUM_STREAMS];
  logic [31:0]       seqNew;
  logic              lenOk;
  logic              accept;

  logic [5:0]        hdrLen;
  logic [15:0]       hdrStream;
  logic [15:0]       totLen;
  logic [31:0]       rawWord;
  logic [31:0]       mask;
  logic              lastWordNext;

  logic [31:0]       dataOutNext;
  logic              dataOutValNext;
  logic              dataOutLastNext;
  logic              msgInReadyNext;
  logic              lenErrNext;

  assign lenOk   = (msgIn_len != 6'd0) && (msgIn_len <= 6'(MAX_PAYLOAD_BYTES));
  assign seqNew  = seqTable[msgIn_stream[4:0]] + 32'd1;
  assign padded  = {payloadReg, 24'd0};
  // Index of the final payload word: ceil(len/4) - 1
  assign lastIdx = 4'((7'(lenReg) + 7'd3) >> 2) - 4'd1;

  // Next-state logic plus the values the output registers will take
  always_comb begin
    stateNext       = state;
    wordIdxNext     = wordIdx;
    accept          = 1'b0;
    lenErrNext      = 1'b0;
    dataOutNext     = 32'd0;
    dataOutValNext  = 1'b0;
    dataOutLastNext = 1'b0;
    msgInReadyNext  = 1'b0;
    hdrLen          = lenReg;
    hdrStream       = streamReg;
    totLen          = 16'd0;
    rawWord         = 32'd0;
    mask            = 32'hFFFF_FFFF;
    lastWordNext    = 1'b0;

    case (state)
      IDLE: begin
        if (msgIn_val) begin
          if (lenOk) begin
            accept    = 1'b1;
            stateNext = HDR0;
          end else begin
            lenErrNext = 1'b1;
          end
        end
      end
      HDR0: if (dataOut_ready) stateNext = HDR1;
      HDR1: begin
        wordIdxNext = 4'd0;
        if (dataOut_ready) stateNext = DATA;
      end
      DATA: begin
        if (dataOut_ready) begin
          if (wordIdx == lastIdx) stateNext = IDLE;
          else wordIdxNext = wordIdx + 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Header word0 is built from the live inputs on the acceptance cycle
    if (accept) begin
      hdrLen    = msgIn_len;
      hdrStream = msgIn_stream;
    end
    totLen       = 16'(hdrLen) + 16'd8;
    rawWord      = padded[{wordIdxNext, 5'd0} +: 32];
    lastWordNext = (wordIdxNext == lastIdx);
    if (lastWordNext) begin
      case (lenReg[1:0])
        2'd1:    mask = 32'hFF00_0000;
        2'd2:    mask = 32'hFFFF_0000;
        2'd3:    mask = 32'hFFFF_FF00;
        default: mask = 32'hFFFF_FFFF;
      endcase
    end

    msgInReadyNext = (stateNext == IDLE);
    case (stateNext)
      HDR0: begin
        dataOutValNext = 1'b1;
        dataOutNext    = {totLen[7:0], totLen[15:8], hdrStream[7:0], hdrStream[15:8]};
      end
      HDR1: begin
        dataOutValNext = 1'b1;
        dataOutNext    = {seqReg[7:0], seqReg[15:8], seqReg[23:16], seqReg[31:24]};
      end
      DATA: begin
        dataOutValNext  = 1'b1;
        dataOutNext     = rawWord & mask;
        dataOutLastNext = lastWordNext;
      end
      default: ;
    endcase
  end

  // State, message capture, sequence table and output registers
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state        <= IDLE;
      wordIdx      <= 4'd0;
      payloadReg   <= '0;
      lenReg       <= 6'd0;
      streamReg    <= 16'd0;
      seqReg       <= 32'd0;
      for (int i = 0; i < int'(NUM_STREAMS); i++) seqTable[i] <= 32'd0;
      dataOut      <= 32'd0;
      dataOut_val  <= 1'b0;
      dataOut_last <= 1'b0;
      msgIn_ready  <= 1'b1;
      lenErr       <= 1'b0;
    end else begin
      state   <= stateNext;
      wordIdx <= wordIdxNext;
      if (accept) begin
        payloadReg                   <= msgIn;
        lenReg                       <= msgIn_len;
        streamReg                    <= msgIn_stream;
        seqReg                       <= seqNew;
        seqTable[msgIn_stream[4:0]]  <= seqNew;
      end
      dataOut      <= dataOutNext;
      dataOut_val  <= dataOutValNext;
      dataOut_last <= dataOutLastNext;
      msgIn_ready  <= msgInReadyNext;
      lenErr       <= lenErrNext;
    end
  end

endmodule

// File: tb/tb_seq_packetizer.sv
// Self-checking bench for seq_packetizer: directed scenarios plus random
// messages against a byte-level packet model with its own sequence table.
module tb_seq_packetizer;

  logic         clk = 1'b0;
  logic         reset_b;
  logic [0:295] msgIn;
  logic [5:0]   msgIn_len;
  logic [15:0]  msgIn_stream;
  logic         msgIn_val;
  logic         msgIn_ready;
  logic [31:0]  dataOut;
  logic         dataOut_val;
  logic         dataOut_ready = 1'b1;
  logic         dataOut_last;
  logic         lenErr;

  int total = 0;
  int bad   = 0;

  logic [32:0]  expQ [$];
  logic [31:0]  wordLog [$];
  int unsigned  refSeq [32];
  int           xferCount  = 0;
  int           lenErrSeen = 0;
  int           lenErrWant = 0;
  bit           rndReady   = 1'b0;
  logic         forcedReady = 1'b1;

  logic         prevStall = 1'b0;
  logic         prevLastXfer = 1'b0;
  logic [31:0]  prevData = 32'd0;
  logic         prevLast = 1'b0;
  logic [32:0]  expWord;

  seq_packetizer dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .msgIn        (msgIn),
    .msgIn_len    (msgIn_len),
    .msgIn_stream (msgIn_stream),
    .msgIn_val    (msgIn_val),
    .msgIn_ready  (msgIn_ready),
    .dataOut      (dataOut),
    .dataOut_val  (dataOut_val),
    .dataOut_ready(dataOut_ready),
    .dataOut_last (dataOut_last),
    .lenErr       (lenErr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Downstream ready changes shortly after the rising edge
  always @(posedge clk) begin
    #2;
    dataOut_ready = rndReady ? ($urandom_range(0, 3) != 0) : forcedReady;
  end

  // Output monitor: protocol rules and in-order comparison against the model
  always @(negedge clk) begin
    if (!reset_b) begin
      prevStall    = 1'b0;
      prevLastXfer = 1'b0;
    end else begin
      if (!dataOut_val) begin
        chk("idle_data", dataOut, 32'd0);
        chk("idle_last", 32'(dataOut_last), 32'd0);
      end else begin
        chk("busy_rdy", 32'(msgIn_ready), 32'd0);
      end
      if (prevStall) begin
        chk("hold_val",  32'(dataOut_val), 32'd1);
        chk("hold_data", dataOut, prevData);
        chk("hold_last", 32'(dataOut_last), 32'(prevLast));
      end
      if (prevLastXfer) begin
        chk("rdy_back", 32'(msgIn_ready), 32'd1);
        chk("bubble",   32'(dataOut_val), 32'd0);
      end
      if (lenErr) lenErrSeen++;
      if (dataOut_val && dataOut_ready) begin
        xferCount++;
        wordLog.push_back(dataOut);
        if (expQ.size() == 0) begin
          chk("unexpected_word", dataOut, 32'hDEAD_BEEF);
        end else begin
          expWord = expQ.pop_front();
          chk("word", dataOut, expWord[31:0]);
          chk("last", 32'(dataOut_last), 32'(expWord[32]));
        end
      end
      prevStall    = dataOut_val && !dataOut_ready;
      prevData     = dataOut;
      prevLast     = dataOut_last;
      prevLastXfer = dataOut_val && dataOut_ready && dataOut_last;
    end
  end

  task automatic clearModel();
    for (int i = 0; i < 32; i++) refSeq[i] = 0;
    expQ.delete();
  endtask

  // Offer one message; the model predicts the packet from the byte rules
  task automatic sendMsg(input logic [15:0] s, input logic [5:0] len, input logic [0:295] pl);
    int          guard = 0;
    logic [15:0] tl;
    logic [31:0] seq;
    logic [31:0] w;
    @(negedge clk);
    while (msgIn_ready !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      chk("accept_timeout", 32'(guard), 32'd0);
      return;
    end
    msgIn        = pl;
    msgIn_len    = len;
    msgIn_stream = s;
    msgIn_val    = 1'b1;
    if (len == 6'd0 || len > 6'd37) begin
      lenErrWant++;
    end else begin
      refSeq[s[4:0]] = refSeq[s[4:0]] + 1;
      seq = refSeq[s[4:0]];
      tl  = 16'(len) + 16'd8;
      expQ.push_back({1'b0, tl[7:0], tl[15:8], s[7:0], s[15:8]});
      expQ.push_back({1'b0, seq[7:0], seq[15:8], seq[23:16], seq[31:24]});
      for (int k = 0; k < int'(len); k += 4) begin
        w = 32'd0;
        for (int b = 0; b < 4; b++)
          if (k + b < int'(len)) w[31-8*b -: 8] = pl[8*(k+b) +: 8];
        expQ.push_back({1'(k + 4 >= int'(len)), w});
      end
    end
    @(negedge clk);
    msgIn_val = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((expQ.size() != 0 || dataOut_val) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", 32'(expQ.size()), 32'd0);
    @(negedge clk);
  endtask

  function automatic logic [0:295] rndPayload();
    logic [0:295] p;
    for (int j = 0; j < 9; j++) p[32*j +: 32] = $urandom;
    p[288 +: 8] = 8'($urandom);
    return p;
  endfunction

  initial begin
    logic [0:295] pl;
    logic [31:0]  tmp;
    logic [15:0]  s;
    logic [5:0]   len;
    int           base;
    int           xb;
    int           eb;
    int           guard;

    reset_b = 1'b0;
    msgIn = '0; msgIn_len = 6'd0; msgIn_stream = 16'd0; msgIn_val = 1'b0;
    clearModel();
    repeat (2) @(negedge clk);
    chk("rst_val",   32'(dataOut_val), 32'd0);
    chk("rst_data",  dataOut, 32'd0);
    chk("rst_last",  32'(dataOut_last), 32'd0);
    chk("rst_lenerr", 32'(lenErr), 32'd0);
    chk("rst_ready", 32'(msgIn_ready), 32'd1);
    #2 reset_b = 1'b1;

    // Stream 3, len 5; bytes beyond the length must be zeroed
    pl = '0;
    pl[0 +: 40]  = 40'hAA_BB_CC_DD_EE;
    pl[40 +: 24] = 24'h12_34_56;
    base = wordLog.size();
    sendMsg(16'd3, 6'd5, pl);
    waitDrain();
    chk("t1_w0", wordLog[base],     32'h0D00_0300);
    chk("t1_w1", wordLog[base + 1], 32'h0100_0000);
    chk("t1_w2", wordLog[base + 2], 32'hAABB_CCDD);
    chk("t1_w3", wordLog[base + 3], 32'hEE00_0000);

    // Stream 3 again, then stream 0x23 aliasing the same table entry
    base = wordLog.size();
    sendMsg(16'd3, 6'd4, rndPayload());
    sendMsg(16'h0023, 6'd4, rndPayload());
    waitDrain();
    chk("t2_seq2",  wordLog[base + 1], 32'h0200_0000);
    chk("t2_hdr35", wordLog[base + 3], 32'h0C00_2300);
    chk("t2_seq3",  wordLog[base + 4], 32'h0300_0000);

    // Backpressure for three cycles while payload word 1 is presented
    xb = xferCount;
    sendMsg(16'd5, 6'd9, rndPayload());
    guard = 0;
    while (xferCount < xb + 3 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("bp_reach", 32'(guard < 100), 32'd1);
    forcedReady = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    forcedReady = 1'b1;
    waitDrain();
    chk("bp_xfers", 32'(xferCount - xb), 32'd5);

    // Maximum length, bytes 0x01..0x25
    pl = '0;
    for (int k = 0; k < 37; k++) pl[8*k +: 8] = 8'(k + 1);
    base = wordLog.size();
    sendMsg(16'd9, 6'd37, pl);
    waitDrain();
    tmp = wordLog[base];
    chk("max_len_hdr", 32'(tmp[31:16]), 32'h0000_2D00);
    chk("max_words",   32'(wordLog.size() - base), 32'd12);
    chk("max_last",    wordLog[base + 11], 32'h2500_0000);

    // Illegal lengths on stream 7 leave the table untouched
    xb = xferCount;
    eb = lenErrSeen;
    sendMsg(16'd7, 6'd0, rndPayload());
    sendMsg(16'd7, 6'd38, rndPayload());
    repeat (3) @(negedge clk);
    chk("ill_pulses", 32'(lenErrSeen - eb), 32'd2);
    chk("ill_noout",  32'(xferCount - xb), 32'd0);
    base = wordLog.size();
    sendMsg(16'd7, 6'd6, rndPayload());
    waitDrain();
    chk("ill_seq1", wordLog[base + 1], 32'h0100_0000);

    // Random messages, aliased stream IDs, random downstream ready
    rndReady = 1'b1;
    for (int n = 0; n < 40; n++) begin
      s      = 16'($urandom);
      s[4:0] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        len = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(38, 63));
      else
        len = 6'($urandom_range(1, 37));
      sendMsg(s, len, rndPayload());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    waitDrain();
    rndReady = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while payload words are being sent
    sendMsg(16'd3, 6'd20, rndPayload());
    repeat (3) @(negedge clk);
    #2 reset_b = 1'b0;
    #1;
    chk("arst_val",   32'(dataOut_val), 32'd0);
    chk("arst_data",  dataOut, 32'd0);
    chk("arst_last",  32'(dataOut_last), 32'd0);
    chk("arst_ready", 32'(msgIn_ready), 32'd1);
    clearModel();
    xb = xferCount;
    repeat (3) @(negedge clk);
    #2 reset_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_nowords", 32'(xferCount - xb), 32'd0);
    base = wordLog.size();
    sendMsg(16'd3, 6'd8, rndPayload());
    waitDrain();
    chk("arst_seq1", wordLog[base + 1], 32'h0100_0000);

    chk("lenerr_total", 32'(lenErrSeen), 32'(lenErrWant));
    chk("q_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_packetizer.md
# seq_packetizer

Transmit-side packet builder for the per-stream sequenced word protocol. It accepts one fixed-width message per handshake, consisting of a payload, a payload length and a stream ID. It emits the message as a packet on a 32-bit val/ready/last word stream: a two-word header (length, stream, sequence) followed by zero-padded payload words. It keeps a per-stream sequence table, so a downstream sequence-checking parser sees contiguous sequence numbers starting at 1.

## Interface
- NUM_STREAMS, 32: number of sequence table entries; index = stream[4:0]; fixed at 32.
- MAX_PAYLOAD_BYTES, 37: largest legal payload; equals the msgIn width / 8.

- clk  in  1  single clock; all state changes on its rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- msgIn  in  [0:295]  payload; byte k = msgIn[8k:8k+7], byte 0 is sent first.
- msgIn_len  in  6  payload byte count; legal range 1..37.
- msgIn_stream  in  16  stream ID.
- msgIn_val  in  1  message valid.
- msgIn_ready  out  1  block can accept a message.
- dataOut  out  32  packet word.
- dataOut_val  out  1  dataOut valid.
- dataOut_ready  in  1  downstream accepts the word.
- dataOut_last  out  1  current word is the final word of the packet.
- lenErr  out  1  one-cycle pulse when a message with an illegal length is dropped.

## Operation
- State machine: IDLE, HDR0, HDR1, DATA.
  - IDLE: msgIn_ready=1.
    - On msgIn_val with legal length: register payload, length and stream; compute seq = seqTable[stream[4:0]] + 1 (mod 2^32); write seq back to the table in the same cycle; go to HDR0.
    - On msgIn_val with msgIn_len==0 or >37: complete the handshake, pulse lenErr next cycle, leave the table untouched, stay in IDLE.
  - HDR0: send word0. Advance to HDR1 on dataOut_ready.
  - HDR1: send word1, then clear the word index. Advance to DATA on dataOut_ready.
  - DATA: send payload word i. dataOut_last=1 when i == ceil(len/4)-1. On a transfer of the last word, go to IDLE; otherwise i+1.
- Header byte order (little-endian fields, first byte in [31:24]):
  - Total length L = msgIn_len + 8, 16 bits.
  - word0 = {L[7:0], L[15:8], stream[7:0], stream[15:8]}.
  - word1 = {seq[7:0], seq[15:8], seq[23:16], seq[31:24]}.
- Payload word i = msgIn[32i : 32i+31].
  - Bytes beyond msgIn_len in the last word are forced to 0; with r = len mod 4, r=1 keeps [31:24], r=2 keeps [31:16], r=3 keeps [31:8], r=0 keeps the full word.
  - Word 9 uses only msgIn[288:295] as [31:24]; the rest is 0.
- dataOut_last is 0 on header words. dataOut and dataOut_last are 0 whenever dataOut_val=0.
- Stream IDs differing only above bit 4 share a table entry. The full 16-bit ID still appears in the header.
- Sequence numbers wrap 0xFFFFFFFF -> 0x00000000 with no special handling.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; all 32 table entries = 0.
  - dataOut_val=0, dataOut=0, dataOut_last=0, lenErr=0, msgIn_ready=1.
  - Asserting reset mid-packet abandons the packet; no further words are emitted.
- Latency: a message accepted at edge n has word0 valid after edge n (cycle n+1).
- Minimum packet time is 2+W cycles, where W = ceil(len/4). msgIn_ready rises in the cycle after the last word transfers, giving a one-cycle bubble between packets.
- Output rule: once dataOut_val=1, dataOut, dataOut_last and dataOut_val hold stable until a cycle with dataOut_ready=1. val never depends combinationally on ready.
- msgIn_ready=0 in HDR0, HDR1 and DATA. msgIn is not sampled in those states.
- Table write occurs at acceptance. A packet aborted by reset is lost along with the whole table.

## Test plan
- Reset, then stream 3, len 5, payload AA BB CC DD EE, dataOut_ready held 1:
  - Words: 0x0D000300, 0x01000000, 0xAABBCCDD, 0xEE000000 with last=1 on the fourth word only.
  - msgIn_ready returns to 1 one cycle after the last word.
- Stream 3 len 4 again, then stream 35 (0x0023) len 4:
  - word1 values 0x02000000 and 0x03000000.
  - Second word0 = 0x0C002300.
- Backpressure: len 9 packet with dataOut_ready low for 3 cycles during payload word 1:
  - dataOut, val and last are held unchanged throughout.
  - Word order and values are unaltered; exactly 5 transfers.
- Max length, len 37, payload bytes 0x01..0x25:
  - word0 = 0x2D00xxxx.
  - 10 payload words; last word = 0x25000000 with last=1.
- Illegal lengths: len 0, then len 38, on stream 7:
  - Each completes its handshake, lenErr pulses once each, no dataOut_val.
  - The following legal stream-7 packet carries seq 1.
- Async reset asserted while in DATA:
  - Outputs drop to 0 without waiting for a clock edge.
  - After release, the next stream-3 packet carries seq 1 (0x01000000).
